// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the rom_reader block.
package rom_reader_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Output buffer depth; also the total number of words that may be
    // outstanding (buffered + in flight from the ROM) at any time.
    localparam int BUF_DEPTH = 2;

    // True when a new read may be issued this cycle. A beat leaving the
    // buffer this cycle frees its slot in time for the new word.
    function automatic logic has_credit(input logic [1:0] occ,
                                        input logic       inflight,
                                        input logic       pop);
        int credit;
        credit = BUF_DEPTH - int'(occ) - int'(inflight) + int'(pop);
        return (credit > 0);
    endfunction

endpackage

// File: rtl/rom_reader_fifo2.sv
// Two-entry synchronous FIFO holding {last, data} words for the stream
// output. The head word is forced to zero when the FIFO is empty so the
// stream outputs read as zero whenever nothing is valid.
module rom_reader_fifo2
    import rom_reader_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem_q [BUF_DEPTH];
    logic [W-1:0] mem_d [BUF_DEPTH];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   occ_q, occ_d;
    logic         pop_ok;

    assign pop_ok     = pop && (occ_q != 2'd0);
    assign head_valid = (occ_q != 2'd0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign occupancy  = occ_q;

    // Next-state: write at wr_ptr on push, advance rd_ptr on pop
    always_comb begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (push && (wr_ptr_q == i[0])) begin
                mem_d[i] = push_data;
            end
        end
        wr_ptr_d = push   ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_ok ? ~rd_ptr_q : rd_ptr_q;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop_ok};
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/rom_reader.sv
// Read initiator for a synchronous ROM with 1-cycle read latency.
// Walks a run of addresses on start and streams the words out through a
// two-entry credit-managed buffer. Optional build macro
// ROM_READER_CHECKSUM_EN adds a running modulo-2**DATA_W checksum output.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rd,
    output logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef ROM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] add_q, add_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              infl_last_q, infl_last_d;
    logic              done_q, done_d;
    logic              pop;
    logic [1:0]        occ;
    logic              can_issue;

    // The word returned by the ROM this cycle goes straight into the buffer
    rom_reader_fifo2 #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  ({infl_last_q, rom_data}),
        .pop        (pop),
        .head_data  ({out_last, out_data}),
        .head_valid (out_valid),
        .occupancy  (occ)
    );

    assign pop       = out_valid && out_ready;
    assign can_issue = has_credit(occ, inflight_q, pop);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign add       = add_q;

    // Next-state, read issue and completion logic
    always_comb begin
        state_d     = state_q;
        add_d       = add_q;
        remaining_d = remaining_q;
        inflight_d  = 1'b0;
        infl_last_d = 1'b0;
        done_d      = 1'b0;
        rd          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        add_d       = start_addr;
                        remaining_d = count;
                        state_d     = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (can_issue) begin
                    rd          = 1'b1;
                    add_d       = add_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    inflight_d  = 1'b1;
                    infl_last_d = (remaining_q == {{ADDR_W{1'b0}}, 1'b1});
                    if (remaining_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset drops any read still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            add_q       <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            add_q       <= add_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

`ifdef ROM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    assign checksum = checksum_q;

    // Running sum of accepted beats, cleared when a start is accepted
    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == ST_IDLE) && start) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q + out_data;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end
`endif

endmodule

// File: doc/rom_reader.md
# rom_reader

Read initiator for the synchronous `rom` block. On a `start` command it walks a programmable run of addresses. It drives `rd`/`add` into the ROM and absorbs the ROM's fixed 1-cycle read latency. Each word is delivered on a valid/ready stream, with a 2-entry credit-based buffer so downstream backpressure never loses data. It sits between the `rom` instance and any consumer of table data (display driver, pattern generator, serializer).

## Interface
Parameters:
- `ADDR_W`, default 3: ROM address width; DEPTH = 2**ADDR_W.
- `DATA_W`, default 8: ROM word width.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: command strobe, sampled only in IDLE.
- `start_addr`  in  ADDR_W: first address of the run.
- `count`  in  ADDR_W+1: number of words to read (0..2*DEPTH-1).
- `busy`  out  1: high whenever state is not IDLE.
- `done`  out  1: 1-cycle pulse when a run completes.
- `rd`  out  1: ROM read enable.
- `add`  out  ADDR_W: ROM address.
- `rom_data`  in  DATA_W: ROM `data_out`, valid the cycle after `rd`.
- `out_data`  out  DATA_W: stream data.
- `out_valid`  out  1: stream valid.
- `out_ready`  in  1: stream ready.
- `out_last`  out  1: marks the final word of the run; qualified by `out_valid`.

## Operation
States:
- IDLE
  - `start`=1 and `count`≠0: latch `start_addr` and `count`, then go to RUN.
  - `start`=1 and `count`=0: pulse `done` next cycle and stay in IDLE.
- RUN
  - Issue one read per cycle while credit > 0.
  - Go to DRAIN in the cycle the count-th read issues.
- DRAIN
  - `rd`=0.
  - When the beat with `out_last` is accepted, go to IDLE and pulse `done` that next cycle.

Credit rule:
- credit = 2 − occupancy − inflight + (`out_valid` & `out_ready`).
- `rd`=1 only when credit > 0. Occupancy + inflight never exceeds 2.

Read pipeline:
- A read issued in cycle N returns `rom_data` in cycle N+1.
- That word is written into the buffer at the end of N+1; inflight is the 1-bit flag for the read issued in the previous cycle.

Addressing:
- `add` increments by 1 per issued read, modulo DEPTH (wrap 7→0 at default).
- `count` > DEPTH re-reads wrapped locations.

Stream rules:
- Words leave the buffer in order. A beat transfers when `out_valid` & `out_ready`.
- `out_data`/`out_last` hold stable while `out_valid`=1 and `out_ready`=0.

Other rules:
- `start` is ignored while `busy`=1.
- `rd` is 0 outside RUN. `add` holds its last value.

## Timing
- Reset: `busy`, `done`, `rd`, `out_valid`, `out_last` = 0; `add` = 0; `out_data` = 0; buffer emptied; state IDLE.
- Reset mid-run aborts the run with no `done` pulse; a pending ROM return is discarded.
- `start` sampled in cycle 0:
  - `busy`=1 and first `rd` in cycle 1.
  - First `out_valid` in cycle 3.
- With `out_ready` held 1, throughput is 1 word/cycle. An n-word run gives `out_valid` on cycles 3..n+2 and `done` in cycle n+3.
- `count`=0: `done` in cycle 1, no `rd`.

## Configuration
- `ROM_READER_CHECKSUM_EN` defined:
  - Adds output `checksum` [DATA_W]: the modulo-2**DATA_W sum of all accepted words of the current run.
  - Cleared on `start` acceptance and on `rst`.
  - Valid and stable from the `done` pulse until the next accepted `start`.
- Macro undefined: no `checksum` port and no adder logic.

## Structure
- Package `rom_reader_pkg`: state enum (IDLE, RUN, DRAIN) and the buffer depth constant (2).
- One sub-module `rom_reader_fifo2`: 2-entry synchronous FIFO of {last, data} with occupancy output. The credit logic stays in the top module.

## Test plan
The bench instantiates `rom` (contents 108,10,106,56,45,130,201,217) behind `rom_reader`.
- `start_addr`=0, `count`=8, `out_ready`=1 → 108,10,106,56,45,130,201,217 on cycles 3–10; `out_last` on 217; `done` in cycle 11.
- `start_addr`=6, `count`=4 → 201,217,108,10 (wrap); `out_last` on 10.
- `count`=0 → `done` in cycle 1, `rd` never asserted, no `out_valid`.
- `count`=8 with `out_ready` low for 5 cycles mid-run, then random toggling → same 8 words in order, none lost or duplicated; `rd` never high while occupancy+inflight=2.
- `rst` asserted in cycle 5 of an 8-word run → all outputs 0 the next cycle, no `done`; a following run with `start_addr`=2, `count`=2 yields 106,56.
- With `ROM_READER_CHECKSUM_EN`: full 8-word run → `checksum`=105 (873 mod 256) at `done`; `start_addr`=5, `count`=2 → 75.
